// File: rtl/bus_config_sequencer_pkg.sv
// Shared types and constants for the front-panel bus configuration sequencer.
package bus_cfg_pkg;

  localparam int MASTER_COUNT           = 2;
  localparam int DATA_WIDTH             = 16;
  localparam int ADDR_WIDTH             = 12;
  localparam int MAX_MASTER_WRITE_DEPTH = 16;
  localparam int WR_ADDR_WIDTH          = $clog2(MAX_MASTER_WRITE_DEPTH);

  // Switch field positions; every field is right-aligned on SW[0].
  localparam int SW_WIDTH     = 18;
  localparam int SW_SLAVE_LSB = 0;
  localparam int SW_RW_LSB    = 0;
  localparam int SW_EXT_LSB   = 0;
  localparam int SW_DATA_LSB  = 0;
  localparam int SW_ADDR_LSB  = 0;

  // The encoding is shown on the HEX/LCD display, so the order is fixed.
  typedef enum logic [3:0] {
    SLAVE_SEL = 4'd0,
    RW_SEL    = 4'd1,
    EXT_SEL   = 4'd2,
    EXT_WR0   = 4'd3,
    EXT_WR1   = 4'd4,
    START0    = 4'd5,
    START1    = 4'd6,
    END0      = 4'd7,
    END1      = 4'd8,
    READY     = 4'd9,
    RUN       = 4'd10,
    READOUT   = 4'd11
  } cfg_state_t;

  // 00 = no slave, 01..11 = slave 1..3
  typedef logic [1:0] slave_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } operation_t;

endpackage

// File: rtl/bus_config_sequencer_if.sv
// Configuration and traffic signals between the sequencer and the bus fabric.
interface bus_config_sequencer_if;
  import bus_cfg_pkg::*;

  logic [2*MASTER_COUNT-1:0]          m_slave_sel;
  logic [MASTER_COUNT-1:0]            m_rw;
  logic [MASTER_COUNT-1:0]            m_ext_en;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_start_addr;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_end_addr;
  logic                               ext_wr_en;
  logic                               ext_wr_master;
  logic [WR_ADDR_WIDTH-1:0]           ext_wr_addr;
  logic [DATA_WIDTH-1:0]              ext_wr_data;
  logic                               com_start;
  logic [ADDR_WIDTH-1:0]              rd_addr;
  logic                               com_done;

  modport master (
    output m_slave_sel, m_rw, m_ext_en, m_start_addr, m_end_addr,
    output ext_wr_en, ext_wr_master, ext_wr_addr, ext_wr_data,
    output com_start, rd_addr,
    input  com_done
  );

  modport slave (
    input  m_slave_sel, m_rw, m_ext_en, m_start_addr, m_end_addr,
    input  ext_wr_en, ext_wr_master, ext_wr_addr, ext_wr_data,
    input  com_start, rd_addr,
    output com_done
  );

endinterface

// File: rtl/bus_config_sequencer_key_press_pulse.sv
// Synchronises an active-low push-button level and emits one pulse per press.
module key_press_pulse (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  logic sync1, sync2, prev;

  // Two-flop synchroniser plus a history flop, all preset to "released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // High for the single cycle where the synchronised level has just fallen.
  assign pulse = prev & ~sync2;

endmodule

// File: rtl/bus_config_sequencer.sv
// Front-panel configuration sequencer: walks the user through slave/rw/ext-write
// setup, address windows, the run handshake and the post-run read-out address.
module bus_config_sequencer
  import bus_cfg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump_stateN,
  input  logic                    jump_next_addrN,
  input  logic [SW_WIDTH-1:0]     sw,
  bus_config_sequencer_if.master  bus,
  output logic [3:0]              cfg_state,
  output logic                    communication_ready,
  output logic                    communication_done
);

  localparam logic [WR_ADDR_WIDTH-1:0] LAST_WR_ADDR =
    WR_ADDR_WIDTH'(MAX_MASTER_WRITE_DEPTH - 1);

  cfg_state_t state_q, state_d;

  logic [2*MASTER_COUNT-1:0]          slave_sel_q, slave_sel_d;
  logic [MASTER_COUNT-1:0]            rw_q, rw_d;
  logic [MASTER_COUNT-1:0]            ext_en_q, ext_en_d;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] start_q, start_d;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] end_q, end_d;
  logic                               ext_wr_en_q, ext_wr_en_d;
  logic                               ext_wr_master_q, ext_wr_master_d;
  logic [WR_ADDR_WIDTH-1:0]           ext_wr_addr_q, ext_wr_addr_d;
  logic [DATA_WIDTH-1:0]              ext_wr_data_q, ext_wr_data_d;
  logic [WR_ADDR_WIDTH-1:0]           wr_cnt_q, wr_cnt_d;
  logic                               com_start_q, com_start_d;
  logic [ADDR_WIDTH-1:0]              rd_addr_q, rd_addr_d;

  logic                               js, jn;
  logic [ADDR_WIDTH-1:0]              sw_addr;
  logic [MASTER_COUNT-1:0]            sw_ext;
  logic [DATA_WIDTH-1:0]              sw_data;
  logic                               unused_sw;

  key_press_pulse u_jump_state (
    .clk   (clk),
    .rst   (rst),
    .key_n (jump_stateN),
    .pulse (js)
  );

  key_press_pulse u_jump_next_addr (
    .clk   (clk),
    .rst   (rst),
    .key_n (jump_next_addrN),
    .pulse (jn)
  );

  assign sw_addr   = sw[SW_ADDR_LSB +: ADDR_WIDTH];
  assign sw_ext    = sw[SW_EXT_LSB +: MASTER_COUNT];
  assign sw_data   = sw[SW_DATA_LSB +: DATA_WIDTH];
  assign unused_sw = ^sw[SW_WIDTH-1:DATA_WIDTH];

  // State and configuration registers; reset discards all configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= SLAVE_SEL;
      slave_sel_q     <= '0;
      rw_q            <= '0;
      ext_en_q        <= '0;
      start_q         <= '0;
      end_q           <= '0;
      ext_wr_en_q     <= 1'b0;
      ext_wr_master_q <= 1'b0;
      ext_wr_addr_q   <= '0;
      ext_wr_data_q   <= '0;
      wr_cnt_q        <= '0;
      com_start_q     <= 1'b0;
      rd_addr_q       <= '0;
    end else begin
      state_q         <= state_d;
      slave_sel_q     <= slave_sel_d;
      rw_q            <= rw_d;
      ext_en_q        <= ext_en_d;
      start_q         <= start_d;
      end_q           <= end_d;
      ext_wr_en_q     <= ext_wr_en_d;
      ext_wr_master_q <= ext_wr_master_d;
      ext_wr_addr_q   <= ext_wr_addr_d;
      ext_wr_data_q   <= ext_wr_data_d;
      wr_cnt_q        <= wr_cnt_d;
      com_start_q     <= com_start_d;
      rd_addr_q       <= rd_addr_d;
    end
  end

  // Next-state and register updates; js always wins over jn in the same cycle.
  always_comb begin
    state_d         = state_q;
    slave_sel_d     = slave_sel_q;
    rw_d            = rw_q;
    ext_en_d        = ext_en_q;
    start_d         = start_q;
    end_d           = end_q;
    ext_wr_en_d     = 1'b0;
    ext_wr_master_d = ext_wr_master_q;
    ext_wr_addr_d   = ext_wr_addr_q;
    ext_wr_data_d   = ext_wr_data_q;
    wr_cnt_d        = wr_cnt_q;
    com_start_d     = 1'b0;
    rd_addr_d       = rd_addr_q;

    unique case (state_q)
      SLAVE_SEL: begin
        if (js) begin
          slave_sel_d = sw[SW_SLAVE_LSB +: 2*MASTER_COUNT];
          state_d     = RW_SEL;
        end
      end
      RW_SEL: begin
        if (js) begin
          rw_d    = sw[SW_RW_LSB +: MASTER_COUNT];
          state_d = EXT_SEL;
        end
      end
      EXT_SEL: begin
        if (js) begin
          ext_en_d = sw_ext;
          if (sw_ext[0])      state_d = EXT_WR0;
          else if (sw_ext[1]) state_d = EXT_WR1;
          else                state_d = START0;
        end
      end
      EXT_WR0, EXT_WR1: begin
        // Every key pulse writes one word; js or a full buffer also leaves the state.
        if (js || jn) begin
          ext_wr_en_d     = 1'b1;
          ext_wr_master_d = (state_q == EXT_WR1);
          ext_wr_addr_d   = wr_cnt_q;
          ext_wr_data_d   = sw_data;
          if (js || (wr_cnt_q == LAST_WR_ADDR)) begin
            wr_cnt_d = '0;
            state_d  = ((state_q == EXT_WR0) && ext_en_q[1]) ? EXT_WR1 : START0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      START0: begin
        if (js) begin
          start_d[0 +: ADDR_WIDTH] = sw_addr;
          state_d = START1;
        end
      end
      START1: begin
        if (js) begin
          start_d[ADDR_WIDTH +: ADDR_WIDTH] = sw_addr;
          state_d = END0;
        end
      end
      END0: begin
        if (js) begin
          end_d[0 +: ADDR_WIDTH] = (sw_addr < start_q[0 +: ADDR_WIDTH]) ?
                                   start_q[0 +: ADDR_WIDTH] : sw_addr;
          state_d = END1;
        end
      end
      END1: begin
        if (js) begin
          end_d[ADDR_WIDTH +: ADDR_WIDTH] =
            (sw_addr < start_q[ADDR_WIDTH +: ADDR_WIDTH]) ?
            start_q[ADDR_WIDTH +: ADDR_WIDTH] : sw_addr;
          state_d = READY;
        end
      end
      READY: begin
        if (js) begin
          com_start_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (bus.com_done) state_d = READOUT;
      end
      READOUT: begin
        if (js)      state_d   = SLAVE_SEL;
        else if (jn) rd_addr_d = sw_addr;
      end
      default: state_d = SLAVE_SEL;
    endcase
  end

  assign bus.m_slave_sel   = slave_sel_q;
  assign bus.m_rw          = rw_q;
  assign bus.m_ext_en      = ext_en_q;
  assign bus.m_start_addr  = start_q;
  assign bus.m_end_addr    = end_q;
  assign bus.ext_wr_en     = ext_wr_en_q;
  assign bus.ext_wr_master = ext_wr_master_q;
  assign bus.ext_wr_addr   = ext_wr_addr_q;
  assign bus.ext_wr_data   = ext_wr_data_q;
  assign bus.com_start     = com_start_q;
  assign bus.rd_addr       = rd_addr_q;

  assign cfg_state           = state_q;
  assign communication_ready = (state_q == READY);
  assign communication_done  = (state_q == READOUT);

endmodule
